// File: rtl/uga_dyna_status_rx.sv
// Dynamixel 1.0 status-packet receiver: parses FF FF ID LEN ERR P.. CHK from the UART RX byte
// stream, latches the fields and reports one completion pulse with a result code.
module uga_dyna_status_rx #(
  parameter int MAX_PARAM   = 6,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           arm,
  input  logic                           abort,
  input  logic [7:0]                     rx_byte,
  input  logic                           rx_strobe,
  input  logic [7:0]                     expect_id,
  output logic                           busy,
  output logic                           pkt_done,
  output logic                           pkt_ok,
  output logic [2:0]                     err_code,
  output logic [7:0]                     stat_id,
  output logic [7:0]                     stat_error,
  output logic [$clog2(MAX_PARAM+1)-1:0] stat_nparam,
  output logic [8*MAX_PARAM-1:0]         stat_param
);

  localparam int NP_W  = $clog2(MAX_PARAM + 1);
  localparam int TMR_W = $clog2(TIMEOUT_CYC);
  localparam logic [7:0] LEN_MAX = 8'(MAX_PARAM + 2);

  localparam logic [2:0] ERR_OK  = 3'd0;
  localparam logic [2:0] ERR_CHK = 3'd1;
  localparam logic [2:0] ERR_LEN = 3'd2;
  localparam logic [2:0] ERR_ID  = 3'd3;
  localparam logic [2:0] ERR_TMO = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE, S_HDR1, S_HDR2, S_ID, S_LEN, S_ERR, S_PARAM, S_CHK, S_DONE
  } state_t;

  state_t            state;
  logic [7:0]        sum;
  logic [NP_W-1:0]   cnt;
  logic [TMR_W-1:0]  timer;

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      sum         <= '0;
      cnt         <= '0;
      timer       <= '0;
      pkt_done    <= 1'b0;
      pkt_ok      <= 1'b0;
      err_code    <= '0;
      stat_id     <= '0;
      stat_error  <= '0;
      stat_nparam <= '0;
      stat_param  <= '0;
    end else begin
      pkt_done <= 1'b0;
      if (abort) begin
        state <= S_IDLE;
      end else if (arm) begin
        state       <= S_HDR1;
        sum         <= '0;
        cnt         <= '0;
        timer       <= '0;
        pkt_ok      <= 1'b0;
        err_code    <= '0;
        stat_id     <= '0;
        stat_error  <= '0;
        stat_nparam <= '0;
        stat_param  <= '0;
      end else begin
        case (state)
          S_IDLE: ;
          S_DONE: state <= S_IDLE;
          default: begin
            if (rx_strobe) begin
              timer <= '0;
              case (state)
                S_HDR1: if (rx_byte == 8'hFF) state <= S_HDR2;
                S_HDR2: state <= (rx_byte == 8'hFF) ? S_ID : S_HDR1;
                // Extra FF bytes before the ID are tolerated as additional preamble.
                S_ID: if (rx_byte != 8'hFF) begin
                  stat_id <= rx_byte;
                  sum     <= rx_byte;
                  state   <= S_LEN;
                end
                S_LEN: if (rx_byte < 8'd2 || rx_byte > LEN_MAX) begin
                  err_code <= ERR_LEN;
                  pkt_ok   <= 1'b0;
                  pkt_done <= 1'b1;
                  state    <= S_DONE;
                end else begin
                  sum         <= sum + rx_byte;
                  stat_nparam <= NP_W'(rx_byte - 8'd2);
                  state       <= S_ERR;
                end
                S_ERR: begin
                  stat_error <= rx_byte;
                  sum        <= sum + rx_byte;
                  state      <= (stat_nparam == '0) ? S_CHK : S_PARAM;
                end
                S_PARAM: begin
                  for (int i = 0; i < MAX_PARAM; i++)
                    if (cnt == NP_W'(i)) stat_param[8*i +: 8] <= rx_byte;
                  sum <= sum + rx_byte;
                  cnt <= cnt + 1'b1;
                  if (cnt == stat_nparam - NP_W'(1)) state <= S_CHK;
                end
                S_CHK: begin
                  if (rx_byte != ~sum) begin
                    err_code <= ERR_CHK;
                    pkt_ok   <= 1'b0;
                  end else if (stat_id != expect_id) begin
                    err_code <= ERR_ID;
                    pkt_ok   <= 1'b0;
                  end else begin
                    err_code <= ERR_OK;
                    pkt_ok   <= 1'b1;
                  end
                  pkt_done <= 1'b1;
                  state    <= S_DONE;
                end
                default: ;
              endcase
            end else if (timer == TMR_W'(TIMEOUT_CYC - 1)) begin
              // Idle gap too long: fields keep whatever was received so far.
              err_code <= ERR_TMO;
              pkt_ok   <= 1'b0;
              pkt_done <= 1'b1;
              state    <= S_DONE;
            end else begin
              timer <= timer + 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uga_dyna_status_rx.sv
// Randomized bench for uga_dyna_status_rx: frames are built from field values, expected results
// follow from how each frame was built (and which corruption was applied).
module tb_uga_dyna_status_rx;

  localparam int MAXP = 6;
  localparam int TMO  = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_strobe = 1'b0;
  logic [7:0]  expect_id = 8'h00;
  logic        busy, pkt_done, pkt_ok;
  logic [2:0]  err_code;
  logic [7:0]  stat_id, stat_error;
  logic [2:0]  stat_nparam;
  logic [47:0] stat_param;

  int total = 0;
  int bad = 0;

  uga_dyna_status_rx #(.MAX_PARAM(MAXP), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .rx_byte(rx_byte),
    .rx_strobe(rx_strobe), .expect_id(expect_id), .busy(busy), .pkt_done(pkt_done),
    .pkt_ok(pkt_ok), .err_code(err_code), .stat_id(stat_id), .stat_error(stat_error),
    .stat_nparam(stat_nparam), .stat_param(stat_param)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All drive tasks start and end on a falling edge.
  task automatic send_byte(input logic [7:0] b);
    rx_byte = b;
    rx_strobe = 1'b1;
    @(negedge clk);
    rx_strobe = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " busy"}, 64'(busy), 64'd0);
    check({tag, " done"}, 64'(pkt_done), 64'd0);
    check({tag, " ok"}, 64'(pkt_ok), 64'd0);
    check({tag, " err"}, 64'(err_code), 64'd0);
    check({tag, " id"}, 64'(stat_id), 64'd0);
    check({tag, " erf"}, 64'(stat_error), 64'd0);
    check({tag, " np"}, 64'(stat_nparam), 64'd0);
    check({tag, " par"}, 64'(stat_param), 64'd0);
  endtask

  task automatic run_frame(input string tag, input logic [7:0] b[$], input logic [7:0] eid,
                           input logic [2:0] e_err, input logic [7:0] e_id, input logic [7:0] e_erf,
                           input int e_np, input logic [47:0] e_par);
    bit early = 0;
    expect_id = eid;
    pulse_arm();
    check({tag, " armed busy"}, 64'(busy), 64'd1);
    foreach (b[i]) begin
      if (i > 0) repeat ($urandom_range(0, 3)) begin
        @(negedge clk);
        if (pkt_done) early = 1;
      end
      send_byte(b[i]);
      if (i < b.size() - 1 && pkt_done) early = 1;
    end
    check({tag, " early"}, 64'(early), 64'd0);
    check({tag, " done"}, 64'(pkt_done), 64'd1);
    check({tag, " ok"}, 64'(pkt_ok), 64'(e_err == 3'd0));
    check({tag, " err"}, 64'(err_code), 64'(e_err));
    check({tag, " id"}, 64'(stat_id), 64'(e_id));
    check({tag, " erf"}, 64'(stat_error), 64'(e_erf));
    check({tag, " np"}, 64'(stat_nparam), 64'(e_np));
    check({tag, " par"}, 64'(stat_param), 64'(e_par));
    @(negedge clk);
    check({tag, " done1"}, 64'(pkt_done), 64'd0);
    check({tag, " idle"}, 64'(busy), 64'd0);
    check({tag, " okhold"}, 64'(pkt_ok), 64'(e_err == 3'd0));
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] id, eid, len, erf, s, chk;
    logic [47:0] par;
    logic [2:0] e_err;
    int np, k;
    bit len_bad, chk_bad, id_bad, seen;

    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    send_byte(8'hFF);
    check("idle ignores rx", 64'(busy), 64'd0);

    q = {8'hFF, 8'hFF, 8'h02, 8'h02, 8'h00, 8'hFB};
    run_frame("t1", q, 8'h02, 3'd0, 8'h02, 8'h00, 0, 48'h0);
    q = {8'hFF, 8'hFF, 8'h01, 8'h04, 8'h00, 8'h00, 8'h08, 8'hF2};
    run_frame("t2", q, 8'h01, 3'd0, 8'h01, 8'h00, 2, 48'h0800);
    q = {8'hFF, 8'hFF, 8'h02, 8'h02, 8'h00, 8'hFA};
    run_frame("t3chk", q, 8'h02, 3'd1, 8'h02, 8'h00, 0, 48'h0);
    q = {8'hFF, 8'hFF, 8'h02, 8'h02, 8'h00, 8'hFB};
    run_frame("t3id", q, 8'h03, 3'd3, 8'h02, 8'h00, 0, 48'h0);
    q = {8'h55, 8'hFF, 8'h33, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h02, 8'h00, 8'hFB};
    run_frame("t4sync", q, 8'h02, 3'd0, 8'h02, 8'h00, 0, 48'h0);
    q = {8'hFF, 8'hFF, 8'h02, 8'h09};
    run_frame("t4len", q, 8'h02, 3'd2, 8'h02, 8'h00, 0, 48'h0);

    // Timeout: pkt_done must appear exactly TMO cycles after the last strobe edge.
    expect_id = 8'h02;
    pulse_arm();
    send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h02);
    k = 0;
    while (!pkt_done && k < TMO + 10) begin
      @(negedge clk);
      k++;
    end
    check("tmo latency", 64'(k), 64'(TMO));
    check("tmo err", 64'(err_code), 64'd4);
    check("tmo ok", 64'(pkt_ok), 64'd0);
    check("tmo id", 64'(stat_id), 64'h02);

    // arm together with a strobe: the FF is dropped, so FF 02 .. never forms a header.
    arm = 1'b1; rx_strobe = 1'b1; rx_byte = 8'hFF;
    @(negedge clk);
    arm = 1'b0; rx_strobe = 1'b0;
    seen = 0;
    q = {8'hFF, 8'h02, 8'h02, 8'h00, 8'hFB};
    foreach (q[i]) begin
      send_byte(q[i]);
      if (pkt_done) seen = 1;
    end
    check("armrx no done", 64'(seen), 64'd0);
    check("armrx busy", 64'(busy), 64'd1);
    check("armrx id", 64'(stat_id), 64'd0);

    // abort in the PARAM phase
    expect_id = 8'h01;
    pulse_arm();
    q = {8'hFF, 8'hFF, 8'h01, 8'h04, 8'h00, 8'h00};
    foreach (q[i]) send_byte(q[i]);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort busy", 64'(busy), 64'd0);
    seen = 0;
    repeat (TMO + 4) begin
      if (pkt_done) seen = 1;
      @(negedge clk);
    end
    check("abort no done", 64'(seen), 64'd0);
    check("abort keep np", 64'(stat_nparam), 64'd2);
    check("abort keep id", 64'(stat_id), 64'h01);

    // reset mid-frame
    pulse_arm();
    q = {8'hFF, 8'hFF, 8'h07, 8'h05, 8'h20, 8'h11};
    foreach (q[i]) send_byte(q[i]);
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int n = 0; n < 40; n++) begin
      len_bad = ($urandom_range(0, 5) == 0);
      chk_bad = ($urandom_range(0, 3) == 0);
      id_bad  = ($urandom_range(0, 3) == 0);
      id  = 8'($urandom_range(0, 254));
      eid = id_bad ? (id ^ 8'($urandom_range(1, 255))) : id;
      np  = $urandom_range(0, MAXP);
      erf = 8'($urandom_range(0, 255));
      len = len_bad ? (($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 1))
                                                   : 8'($urandom_range(9, 255)))
                    : 8'(np + 2);
      q = {};
      repeat ($urandom_range(0, 2)) begin
        if ($urandom_range(0, 1) == 1) q.push_back(8'hFF);
        q.push_back(8'($urandom_range(0, 254)));
      end
      repeat ($urandom_range(2, 4)) q.push_back(8'hFF);
      q.push_back(id);
      q.push_back(len);
      par = '0;
      if (len_bad) begin
        e_err = 3'd2;
        run_frame($sformatf("rnd%0d", n), q, eid, e_err, id, 8'h00, 0, par);
      end else begin
        q.push_back(erf);
        s = id + len + erf;
        for (int i = 0; i < np; i++) begin
          par[8*i +: 8] = 8'($urandom_range(0, 255));
          q.push_back(par[8*i +: 8]);
          s = s + par[8*i +: 8];
        end
        chk = ~s;
        if (chk_bad) chk = chk ^ 8'($urandom_range(1, 255));
        q.push_back(chk);
        e_err = chk_bad ? 3'd1 : (id_bad ? 3'd3 : 3'd0);
        run_frame($sformatf("rnd%0d", n), q, eid, e_err, id, erf, np, par);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
